// File: rtl/btn_debounce_pkg.sv
// Purpose : shared definitions for the two-channel push-button conditioner.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: per-channel FSM state encoding and default 20 MHz timing constants.
package btn_debounce_pkg;

    // Per-channel button state. Any state other than REL means the
    // debounced level is 1.
    typedef enum logic [1:0] {
        REL      = 2'd0,   // released, debounced level 0
        HOLD_DLY = 2'd1,   // pressed, waiting for first auto-repeat
        HOLD_RPT = 2'd2    // pressed, auto-repeating
    } btn_state_e;

    // Default timing at the 20 MHz board clock.
    localparam int unsigned DB_CYC_20M  = 200000;  // 10 ms debounce window
    localparam int unsigned RPT_DLY_20M = 200000;  // 10 ms to first repeat
    localparam int unsigned RPT_PER_20M = 100000;  // 5 ms repeat period
    localparam int unsigned CNT_W_20M   = 18;      // holds all of the above

endpackage

// File: rtl/btn_debounce_ch.sv
// Purpose : one button channel: 2-FF synchronizer, debounce counter,
//           press/hold FSM with auto-repeat, registered one-cycle strobe.
// Latency : level changes DB_CYC+1 edges after the raw input is first
//           sampled stable; strobe coincides with the rising level.
// Backpr. : none; strobes are fire-and-forget single-cycle pulses.
// Ports   : i_clk, i_rst_n (async active-low), i_raw (bouncy, pressed=1),
//           o_level (debounced level), o_stb (press / repeat strobe).
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DB_CYC  = DB_CYC_20M,
    parameter int unsigned CNT_W   = CNT_W_20M,
    parameter int unsigned RPT_EN  = 1,
    parameter int unsigned RPT_DLY = RPT_DLY_20M,
    parameter int unsigned RPT_PER = RPT_PER_20M
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_stb
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               RPT_ON   = (RPT_EN != 0);

    // ------------------------------------------------------------------
    // Synchronizer: only r_s2 is used downstream.
    // ------------------------------------------------------------------
    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: count consecutive samples that disagree with the current
    // level; a single agreeing sample restarts the count.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_dcnt;
    logic             r_level;
    logic             w_diff;
    logic             w_accept;
    logic             w_press;
    logic             w_release;

    assign w_diff    = (r_s2 != r_level);
    assign w_accept  = w_diff && (r_dcnt == DB_LAST);
    assign w_press   = w_accept &&  r_s2;
    assign w_release = w_accept && !r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dcnt  <= '0;
            r_level <= 1'b0;
        end else begin
            if (!w_diff || w_accept) begin
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + CNT_ONE;
            end
            if (w_accept) begin
                r_level <= r_s2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Press / hold FSM
    // ------------------------------------------------------------------
    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_rcnt;
    logic             r_stb;
    logic             w_stb_nxt;
    logic             w_rcnt_clr;
    logic             w_rcnt_inc;
    logic             w_dly_done;
    logic             w_per_done;

    // With auto-repeat disabled the first-repeat compare never fires and
    // rcnt is held at zero, so the channel parks in HOLD_DLY.
    assign w_dly_done = RPT_ON && (r_rcnt == DLY_LAST);
    assign w_per_done = (r_rcnt == PER_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= REL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A release accepted on the same edge as a repeat
    // wins: the button is up, so no strobe.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            REL: begin
                if (w_press) begin
                    w_state_nxt = HOLD_DLY;
                end
            end
            HOLD_DLY: begin
                if (w_release) begin
                    w_state_nxt = REL;
                end else if (w_dly_done) begin
                    w_state_nxt = HOLD_RPT;
                end
            end
            HOLD_RPT: begin
                if (w_release) begin
                    w_state_nxt = REL;
                end
            end
            default: begin
                w_state_nxt = REL;
            end
        endcase
    end

    // Output / counter-control logic
    always_comb begin
        w_stb_nxt  = 1'b0;
        w_rcnt_clr = 1'b0;
        w_rcnt_inc = 1'b0;
        case (r_state)
            REL: begin
                w_rcnt_clr = 1'b1;
                w_stb_nxt  = w_press;
            end
            HOLD_DLY: begin
                if (w_release) begin
                    w_rcnt_clr = 1'b1;
                end else if (w_dly_done) begin
                    w_stb_nxt  = 1'b1;
                    w_rcnt_clr = 1'b1;
                end else begin
                    w_rcnt_inc = RPT_ON;
                end
            end
            HOLD_RPT: begin
                if (w_release) begin
                    w_rcnt_clr = 1'b1;
                end else if (w_per_done) begin
                    w_stb_nxt  = 1'b1;
                    w_rcnt_clr = 1'b1;
                end else begin
                    w_rcnt_inc = 1'b1;
                end
            end
            default: begin
                w_rcnt_clr = 1'b1;
            end
        endcase
    end

    // Repeat counter and registered strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rcnt <= '0;
            r_stb  <= 1'b0;
        end else begin
            if (w_rcnt_clr) begin
                r_rcnt <= '0;
            end else if (w_rcnt_inc) begin
                r_rcnt <= r_rcnt + CNT_ONE;
            end
            r_stb <= w_stb_nxt;
        end
    end

    assign o_level = r_level;
    assign o_stb   = r_stb;

endmodule

// File: rtl/btn_debounce.sv
// Purpose : two-channel (UP/DN) push-button conditioner feeding the PLL
//           control stage with debounced levels plus press/repeat strobes.
// Latency : DB_CYC+1 edges from first stable raw sample to level change;
//           strobe coincides with the rising level.
// Backpr. : none; channels are independent and never arbitrated.
// Ports   : CLK, RSTX (async active-low), BTN_UP_RAW/BTN_DN_RAW (bouncy),
//           BTN_UP/BTN_DN (debounced levels), UP_STB/DN_STB (strobes).
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DB_CYC  = DB_CYC_20M,
    parameter int unsigned CNT_W   = CNT_W_20M,
    parameter int unsigned RPT_EN  = 1,
    parameter int unsigned RPT_DLY = RPT_DLY_20M,
    parameter int unsigned RPT_PER = RPT_PER_20M
) (
    input  logic CLK,
    input  logic RSTX,
    input  logic BTN_UP_RAW,
    input  logic BTN_DN_RAW,
    output logic BTN_UP,
    output logic BTN_DN,
    output logic UP_STB,
    output logic DN_STB
);

    btn_debounce_ch #(
        .DB_CYC  (DB_CYC),
        .CNT_W   (CNT_W),
        .RPT_EN  (RPT_EN),
        .RPT_DLY (RPT_DLY),
        .RPT_PER (RPT_PER)
    ) u_ch_up (
        .i_clk   (CLK),
        .i_rst_n (RSTX),
        .i_raw   (BTN_UP_RAW),
        .o_level (BTN_UP),
        .o_stb   (UP_STB)
    );

    btn_debounce_ch #(
        .DB_CYC  (DB_CYC),
        .CNT_W   (CNT_W),
        .RPT_EN  (RPT_EN),
        .RPT_DLY (RPT_DLY),
        .RPT_PER (RPT_PER)
    ) u_ch_dn (
        .i_clk   (CLK),
        .i_rst_n (RSTX),
        .i_raw   (BTN_DN_RAW),
        .o_level (BTN_DN),
        .o_stb   (DN_STB)
    );

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: two instances (auto-repeat on / off) share inputs.
// A window-based reference model predicts levels and strobe cycles into
// queues; a negedge monitor pops and compares every cycle.
module tb_btn_debounce;

    localparam int DB  = 8;
    localparam int DLY = 32;
    localparam int PER = 16;
    localparam int W   = 18;
    localparam int HN  = 16;   // history depth, must exceed DB+2

    logic clk    = 1'b0;
    logic rstx   = 1'b1;
    logic up_raw = 1'b0;
    logic dn_raw = 1'b0;
    logic btn_up, btn_dn, up_stb, dn_stb;
    logic btn_up_n, btn_dn_n, up_stb_n, dn_stb_n;

    btn_debounce #(.DB_CYC(DB), .CNT_W(W), .RPT_EN(1), .RPT_DLY(DLY), .RPT_PER(PER)) u_dut (
        .CLK(clk), .RSTX(rstx), .BTN_UP_RAW(up_raw), .BTN_DN_RAW(dn_raw),
        .BTN_UP(btn_up), .BTN_DN(btn_dn), .UP_STB(up_stb), .DN_STB(dn_stb)
    );

    btn_debounce #(.DB_CYC(DB), .CNT_W(W), .RPT_EN(0), .RPT_DLY(DLY), .RPT_PER(PER)) u_dut_norpt (
        .CLK(clk), .RSTX(rstx), .BTN_UP_RAW(up_raw), .BTN_DN_RAW(dn_raw),
        .BTN_UP(btn_up_n), .BTN_DN(btn_dn_n), .UP_STB(up_stb_n), .DN_STB(dn_stb_n)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int ch;
        int cyc;
    } stb_ev_t;

    stb_ev_t    stb_q[$];
    logic [3:0] lvl_q[$];

    // Channels: 0 = UP (repeat), 1 = DN (repeat), 2 = UP (no repeat), 3 = DN (no repeat)
    bit hist [4][0:HN-1];
    bit m_level [4];
    int press_cyc [4];

    // Reference model: the level flips once the last DB synchronized
    // samples (raw delayed by two edges) all disagree with it. Strobes fall
    // at press offset 0, then DLY, DLY+PER, DLY+2*PER, ... while held.
    always @(posedge clk) begin
        logic [3:0] lv;
        bit         all_diff;
        int         t;
        stb_ev_t    ev;
        cyc++;
        for (int ch = 0; ch < 4; ch++) begin
            if (!rstx) begin
                for (int k = 0; k < HN; k++) hist[ch][k] = 1'b0;
                m_level[ch] = 1'b0;
            end else begin
                for (int k = HN - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
                hist[ch][0] = (ch % 2 == 0) ? up_raw : dn_raw;
                all_diff = 1'b1;
                for (int k = 2; k < DB + 2; k++)
                    if (hist[ch][k] == m_level[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[ch] = !m_level[ch];
                    if (m_level[ch]) press_cyc[ch] = cyc;
                end
                if (m_level[ch]) begin
                    t = cyc - press_cyc[ch];
                    if (t == 0 || (ch < 2 && t >= DLY && (t - DLY) % PER == 0)) begin
                        ev.ch  = ch;
                        ev.cyc = cyc;
                        stb_q.push_back(ev);
                    end
                end
            end
            lv[ch] = m_level[ch];
        end
        lvl_q.push_back(lv);
    end

    // Monitor: compares DUT outputs against the queued predictions.
    always @(negedge clk) begin
        logic [3:0] act_lv, exp_lv, act_stb;
        bit         exp_s;
        act_lv  = {btn_dn_n, btn_up_n, btn_dn, btn_up};
        act_stb = {dn_stb_n, up_stb_n, dn_stb, up_stb};
        if (lvl_q.size() > 0) begin
            exp_lv = lvl_q.pop_front();
            checks++;
            if (act_lv !== exp_lv) begin
                errors++;
                $display("FAIL levels cyc=%0d got=%b expected=%b", cyc, act_lv, exp_lv);
            end
            for (int ch = 0; ch < 4; ch++) begin
                exp_s = (stb_q.size() > 0 && stb_q[0].cyc == cyc && stb_q[0].ch == ch);
                if (exp_s) void'(stb_q.pop_front());
                checks++;
                if (act_stb[ch] !== exp_s) begin
                    errors++;
                    $display("FAIL strobe ch=%0d cyc=%0d got=%b expected=%b", ch, cyc, act_stb[ch], exp_s);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts posedges until btn_up reads val (sampled #1 after the edge);
    // returns -1 if the bound expires.
    task automatic up_edges_until(input logic val, output int n);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            n++;
            #1;
            if (btn_up === val) return;
        end
        n = -1;
    endtask

    // DN pulse of len sampled cycles; tallies DN activity over 50 cycles.
    task automatic pulse_dn(input int len, output int lvl_cnt, output int stb_cnt);
        lvl_cnt = 0;
        stb_cnt = 0;
        dn_raw  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (btn_dn === 1'b1) lvl_cnt++;
            if (dn_stb === 1'b1) stb_cnt++;
            if (i == len - 1) dn_raw = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c, cn, any, mism;
        int tmr [2];

        // 1. Reset with both buttons held
        rstx   = 1'b0;
        up_raw = 1'b1;
        dn_raw = 1'b1;
        cycles(5);
        #1;
        chk("reset_outputs", int'({btn_up, btn_dn, up_stb, dn_stb,
                                   btn_up_n, btn_dn_n, up_stb_n, dn_stb_n}), 0);
        @(negedge clk);
        rstx = 1'b1;
        up_edges_until(1'b1, n);
        chk("t1_up_rise_edges", n, DB + 2);
        chk("t1_stb_at_rise", int'(up_stb), 1);
        @(posedge clk); #1;
        chk("t1_stb_one_cycle", int'(up_stb), 0);
        @(negedge clk);
        up_raw = 1'b0;
        dn_raw = 1'b0;
        cycles(40);

        // 2. Bounce: 3-cycle pulses, then hold
        any = 0;
        for (int i = 0; i < 39; i++) begin
            up_raw = ((i / 3) % 2 == 1);
            @(negedge clk);
            if (btn_up === 1'b1 || up_stb === 1'b1) any++;
        end
        up_raw = 1'b1;
        chk("t2_quiet_during_bounce", any, 0);
        up_edges_until(1'b1, n);
        chk("t2_rise_after_last_edge", n, DB + 2);
        chk("t2_stb_at_rise", int'(up_stb), 1);
        @(negedge clk);
        up_raw = 1'b0;
        cycles(30);

        // 3. Glitch rejection on DN
        pulse_dn(DB - 1, c, cn);
        chk("t3_short_level", c, 0);
        chk("t3_short_stb", cn, 0);
        pulse_dn(DB, c, cn);
        chk("t3_long_level_seen", int'(c > 0), 1);
        chk("t3_long_stb", cn, 1);
        cycles(10);

        // 4. Auto-repeat on UP, both instances
        up_raw = 1'b1;
        up_edges_until(1'b1, n);
        chk("t4_rise_edges", n, DB + 2);
        c  = 0;
        cn = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (up_stb === 1'b1) c++;
            if (up_stb_n === 1'b1) cn++;
        end
        chk("t4_repeat_count", c, 6);
        chk("t4_norpt_count", cn, 1);
        up_raw = 1'b0;
        up_edges_until(1'b0, n);
        chk("t4_fall_edges", n, DB + 2);
        chk("t4_no_stb_on_release", int'(up_stb), 0);
        cycles(20);

        // 5. Simultaneous presses
        up_raw = 1'b1;
        dn_raw = 1'b1;
        mism = 0;
        c    = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (btn_up !== btn_dn || up_stb !== dn_stb) mism++;
            if (up_stb === 1'b1) c++;
        end
        chk("t5_lockstep", mism, 0);
        chk("t5_stb_count", c, 3);

        // 6. Reset during HOLD_RPT with buttons still held
        #1 rstx = 1'b0;
        #1;
        chk("t6_async_clear", int'({btn_up, btn_dn, up_stb, dn_stb,
                                    btn_up_n, btn_dn_n, up_stb_n, dn_stb_n}), 0);
        cycles(3);
        rstx = 1'b1;
        up_edges_until(1'b1, n);
        chk("t6_rise_edges", n, DB + 2);
        chk("t6_fresh_stb", int'(up_stb), 1);
        c = 0;
        for (int i = 0; i < DLY; i++) begin
            @(negedge clk);
            if (up_stb === 1'b1) c++;
        end
        chk("t6_only_press_before_dly", c, 1);
        @(negedge clk);
        chk("t6_first_repeat_at_dly", int'(up_stb), 1);
        up_raw = 1'b0;
        dn_raw = 1'b0;
        cycles(30);

        // 7. Random segments, checked by the monitor alone
        tmr[0] = 0;
        tmr[1] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (tmr[ch] == 0) begin
                    if (ch == 0) up_raw = 1'($urandom_range(0, 1));
                    else         dn_raw = 1'($urandom_range(0, 1));
                    tmr[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 120))
                                                          : int'($urandom_range(1, 12));
                end
                tmr[ch]--;
            end
            @(negedge clk);
        end
        up_raw = 1'b0;
        dn_raw = 1'b0;
        cycles(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Two-channel push-button conditioner for the board's UP/DN buttons.
- Sits directly upstream of the PLL control stage: its debounced levels drive BTN_UP/BTN_DN there, which edge-detects them to step the PLL setting.
- Also emits one-cycle press strobes with optional auto-repeat for future consumers, e.g. a serial-rate selector.
- Runs in the 20 MHz board clock domain.

Parameters:
- DB_CYC, 200000, stable-sample count required to accept a level change (10 ms at 20 MHz); minimum 2.
- CNT_W, 18, width of the debounce and repeat counters; must hold max(DB_CYC, RPT_DLY, RPT_PER).
- RPT_EN, 1, 1 enables auto-repeat strobes while a button is held; 0 disables them.
- RPT_DLY, 200000, held cycles after the press strobe before the first repeat strobe.
- RPT_PER, 100000, cycles between subsequent repeat strobes.

Ports:
- CLK  in  1  board clock, single clock domain.
- RSTX  in  1  asynchronous active-low reset.
- BTN_UP_RAW  in  1  raw UP button, pressed = 1, asynchronous and bouncy.
- BTN_DN_RAW  in  1  raw DN button, pressed = 1.
- BTN_UP  out  1  debounced UP level, pressed = 1.
- BTN_DN  out  1  debounced DN level.
- UP_STB  out  1  one-cycle strobe on accepted UP press or UP repeat.
- DN_STB  out  1  one-cycle strobe on accepted DN press or DN repeat.

Behaviour:
- Reset: all flops clear asynchronously on RSTX low. BTN_UP, BTN_DN, UP_STB and DN_STB are 0; synchronizers are 0; FSM is in REL; counters are 0.
- Per channel, synchronization: raw -> s1 -> s2 (2-FF synchronizer). Only s2 is used downstream.
- Debounce counter dcnt:
  - Cleared whenever s2 == level.
  - Incremented when s2 != level.
  - When s2 != level and dcnt == DB_CYC-1, the channel accepts the change: level <= s2 and dcnt <= 0.
  - Any single-cycle return of s2 to the current level clears dcnt. Glitches shorter than DB_CYC samples are never propagated.
- Latency: raw first sampled at edge e0 -> level changes after edge e(DB_CYC+1), assuming raw is stable throughout. The same latency applies to press and release.
- FSM, per channel:
  - REL: level 0. On acceptance of a press -> HOLD_DLY; assert STB for one cycle; rcnt <= 0.
  - HOLD_DLY: level 1. rcnt increments. If RPT_EN and rcnt == RPT_DLY-1 -> HOLD_RPT; assert STB; rcnt <= 0.
  - HOLD_RPT: level 1. rcnt increments. At rcnt == RPT_PER-1, assert STB and set rcnt <= 0.
  - Any state with level 1: on acceptance of a release -> REL. No strobe on release.
- With RPT_EN = 0, the FSM stays in HOLD_DLY until release; the only strobe is the press strobe.
- Strobe timing: STB is registered and asserts in the cycle level first reads 1. The next repeat strobe is exactly RPT_DLY cycles later, then every RPT_PER cycles after that.
- Channels are fully independent. Simultaneous presses produce coincident UP_STB and DN_STB; no arbitration in this block.
- Reset mid-press: outputs drop to 0 immediately. After RSTX releases while the button is held, the press is re-debounced and a fresh press strobe is emitted.
- Counter widths: dcnt and rcnt saturate-free. They never exceed the compare value, so no wrap occurs for legal parameters.

Decomposition:
- Shared package: FSM state encoding (REL, HOLD_DLY, HOLD_RPT as 2-bit constants) and the default timing constants DB_CYC_20M and RPT_DLY_20M.
- Sub-module btn_debounce_ch: one channel, containing the synchronizer, dcnt, FSM, rcnt and strobe. The top instantiates it twice and only wires ports.

Test Plan:
Parameters for all scenarios: DB_CYC=8, RPT_DLY=32, RPT_PER=16 unless noted.
1. Reset: RSTX low with both raw inputs at 1 -> all outputs 0. Release RSTX with the inputs held at 1 -> BTN_UP rises 10 edges later, and UP_STB pulses high for exactly 1 cycle coincident with that rise.
2. Bounce: raw UP toggles with 3-cycle pulses for 40 cycles, then holds at 1 -> no output activity during bouncing. BTN_UP rises 10 edges after the last 0->1 transition; exactly one UP_STB.
3. Glitch rejection: 7-cycle raw high pulse on DN -> BTN_DN and DN_STB stay 0. An 8-cycle pulse -> BTN_DN is high for at least 1 cycle and DN_STB pulses once.
4. Auto-repeat: hold UP for 100 cycles after acceptance -> UP_STB at offsets 0, 32, 48, 64, 80, 96. Release -> BTN_UP falls 10 edges after raw falls, with no strobe on release. Rerun with RPT_EN=0 -> strobe at offset 0 only.
5. Simultaneous: UP and DN raw rise on the same edge -> BTN_UP/BTN_DN and UP_STB/DN_STB are identical cycle-for-cycle.
6. Reset mid-hold: assert RSTX in HOLD_RPT -> outputs 0 asynchronously, within the same cycle. After deassertion with the input held, a fresh press strobe arrives 10 edges later, and the first repeat strobe follows 32 cycles after that.
